formula_pipe_credit_buffer: RTL and testbench
=============================================

FORMULA_PIPE_CREDIT_BUFFER -- requirements
Module: formula_pipe_credit_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the result data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the result FIFO entries and credit limit (legal: 2..256).
REQ-003 The block SHALL have port clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port arg_vld  input  1  upstream offers an argument set this cycle.
REQ-006 The block SHALL have port arg_rdy  output  1  a credit is free and the argument is accepted when arg_vld is also high.
REQ-007 The block SHALL have port pipe_arg_vld  output  1  equals arg_vld & arg_rdy; drives the valid input of the fixed-latency pipe.
REQ-008 The block SHALL have port pipe_res_vld  input  1  valid-only result strobe from the pipe; there is no backpressure.
REQ-009 The block SHALL have port pipe_res  input  WIDTH  result data from the pipe.
REQ-010 The block SHALL have port res_vld  output  1  FIFO head is valid toward downstream.
REQ-011 The block SHALL have port res  output  WIDTH  FIFO head data.
REQ-012 The block SHALL have port res_rdy  input  1  downstream accepts the head when res_vld is also high.
REQ-013 The block SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-014 Credit counter cnt (width $clog2(DEPTH+1)) SHALL track arguments accepted and not yet popped downstream: +1 on pipe_arg_vld, -1 on pop (res_vld & res_rdy), unchanged when both occur in one cycle.
REQ-015 arg_rdy SHALL be high exactly when registered cnt < DEPTH; there is no combinational path from res_rdy or arg_vld to arg_rdy.
REQ-016 The FIFO SHALL write pipe_res on every pipe_res_vld, using a circular buffer whose read/write pointers wrap from DEPTH-1 to 0.
REQ-017 res_vld SHALL be high exactly when the FIFO is non-empty, and res SHALL be the oldest stored entry, held stable until popped.
REQ-018 A simultaneous FIFO write and pop SHALL leave the occupancy unchanged; on a full FIFO this is legal and preserves entry ordering.
REQ-019 pipe_res_vld arriving while the FIFO is full SHALL drop the data, leave the FIFO unchanged, and set err.
REQ-020 pipe_res_vld arriving while FIFO occupancy >= cnt (a result with no outstanding argument) SHALL be written and SHALL set err.
REQ-021 err SHALL remain set until reset.
REQ-022 Results SHALL leave in the same order the arguments were accepted; the block adds no reordering.
REQ-023 Throughput SHALL be one argument per cycle and one result per cycle while credits are free and res_rdy is high.

Reset
REQ-024 While rst is low, the block SHALL asynchronously set cnt, pointers, occupancy and err to 0, giving arg_rdy=1, pipe_arg_vld=arg_vld, res_vld=0 and err=0.
REQ-025 FIFO storage SHALL NOT be reset, and res is don't-care while res_vld=0.
REQ-026 Reset mid-operation SHALL discard all stored and in-flight results; pipe_res_vld strobes from the pre-reset argument sets arriving after reset deassertion SHALL set err.

Configuration
REQ-027 With macro FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN defined, when the FIFO is empty and res_rdy=1, a pipe_res_vld result SHALL appear combinationally on res/res_vld in the same cycle and SHALL NOT be written to the FIFO.
REQ-028 With FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN defined, REQ-017 SHALL otherwise hold (res_vld = FIFO non-empty | (pipe_res_vld & empty)).
REQ-029 Without FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN, every result SHALL pass through the FIFO, giving a minimum latency of 1 cycle from pipe_res_vld to res_vld.

Verification
REQ-030 Reset then idle -> arg_rdy=1, res_vld=0, err=0 for 10 cycles.
REQ-031 DEPTH=4, pipe latency 5, res_rdy=0, arg_vld held high -> exactly 4 accepts, then arg_rdy=0; four results 0x11..0x44 are stored; res_vld=1 with res=0x11.
REQ-032 From the full state of REQ-031, res_rdy=1 for one cycle -> 0x11 is popped and arg_rdy=1 on the next cycle; a new accept re-fills the buffer; err=0.
REQ-033 Streaming 1000 arguments with random arg_vld/res_rdy and a 33-cycle pipe (data = index) -> results emerge in order 0..999, err=0 and cnt=0 at the end.
REQ-034 Inject pipe_res_vld with cnt=0 -> err=1 and stays 1; then pull rst low mid-stream -> res_vld=0, err=0 and arg_rdy=1 immediately.
REQ-035 With BYPASS_EN, FIFO empty, res_rdy=1 and pipe_res=0xDEADBEEF strobed -> res_vld=1 and res=0xDEADBEEF in the same cycle; without BYPASS_EN -> they appear one cycle later.

Source files
------------

// File: rtl/formula_pipe_credit_buffer.sv
// Credit-gated result buffer for a fixed-latency, valid-only compute pipe.
// Optional same-cycle bypass of an empty FIFO: define FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN.
module formula_pipe_credit_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  output logic             pipe_arg_vld,
  input  logic             pipe_res_vld,
  input  logic [WIDTH-1:0] pipe_res,
  output logic             res_vld,
  output logic [WIDTH-1:0] res,
  input  logic             res_rdy,
  output logic             err
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic             empty, full, pop, fifo_pop, fifo_wr, bypass;

  always_comb begin
    empty        = (occ_q == '0);
    full         = (occ_q == DEPTH_C);
    arg_rdy      = (cnt_q < DEPTH_C);
    pipe_arg_vld = arg_vld & arg_rdy;
`ifdef FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN
    res_vld      = !empty | (pipe_res_vld & empty);
    res          = empty ? pipe_res : mem_q[rd_ptr_q];
    bypass       = empty & pipe_res_vld & res_rdy;
`else
    res_vld      = !empty;
    res          = mem_q[rd_ptr_q];
    bypass       = 1'b0;
`endif
    pop          = res_vld & res_rdy;
    // A bypassed result is popped straight off the pipe, never from storage.
    fifo_pop     = pop & !empty;
    fifo_wr      = pipe_res_vld & !bypass & (!full | fifo_pop);
    // A full FIFO always has occ >= cnt, so the overflow drop is also flagged here.
    err_d        = err_q | (pipe_res_vld & (occ_q >= cnt_q))
                         | (pipe_res_vld & full & !fifo_pop);
    err          = err_q;

    cnt_d = cnt_q;
    unique case ({pipe_arg_vld, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      default: cnt_d = cnt_q;
    endcase

    occ_d = occ_q;
    unique case ({fifo_wr, fifo_pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (fifo_pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately left unreset; res is only meaningful with res_vld.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= pipe_res;
  end

endmodule

// File: tb/tb_formula_pipe_credit_buffer.sv
// Directed bench for formula_pipe_credit_buffer (DEPTH=4) with a behavioural fixed-latency pipe.
module tb_formula_pipe_credit_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arg_vld = 1'b0;
  logic        arg_rdy, pipe_arg_vld;
  logic        pipe_res_vld = 1'b0;
  logic [31:0] pipe_res = '0;
  logic        res_vld;
  logic [31:0] res;
  logic        res_rdy = 1'b0;
  logic        err;

  int checks = 0;
  int errors = 0;

  // behavioural pipe: delay line, slot 0 drives the current cycle
  logic        dl_v [64];
  logic [31:0] dl_d [64];
  int unsigned lat = 5;
  logic        inj_vld = 1'b0;
  logic [31:0] inj_data = '0;

  // per-cycle samples
  logic        s_arg_rdy, s_pav, s_res_vld, s_err, last_acc, last_pop;
  logic [31:0] s_res, last_pop_data;

  formula_pipe_credit_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
    .pipe_arg_vld(pipe_arg_vld), .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .res_vld(res_vld), .res(res), .res_rdy(res_rdy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic clear_pipe();
    for (int i = 0; i < 64; i++) begin
      dl_v[i] = 1'b0;
      dl_d[i] = '0;
    end
  endtask

  task automatic run_cycle(input logic av, input logic rr, input logic [31:0] ad);
    arg_vld      = av;
    res_rdy      = rr;
    pipe_res_vld = dl_v[0] | inj_vld;
    pipe_res     = inj_vld ? inj_data : dl_d[0];
    #1;
    s_arg_rdy     = arg_rdy;
    s_pav         = pipe_arg_vld;
    s_res_vld     = res_vld;
    s_res         = res;
    s_err         = err;
    last_acc      = pipe_arg_vld;
    last_pop      = res_vld & res_rdy;
    last_pop_data = res;
    @(posedge clk);
    #1;
    for (int i = 0; i < 63; i++) begin
      dl_v[i] = dl_v[i+1];
      dl_d[i] = dl_d[i+1];
    end
    dl_v[63] = 1'b0;
    if (last_acc) begin
      dl_v[lat-1] = 1'b1;
      dl_d[lat-1] = ad;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_pipe();
  endtask

  task automatic test_reset();
    arg_vld = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (arg_rdy !== 1'b1) begin errors++; $display("FAIL rst_arg_rdy: got %b expected 1", arg_rdy); end
    checks++; if (pipe_arg_vld !== 1'b1) begin errors++; $display("FAIL rst_pipe_arg_vld: got %b expected 1", pipe_arg_vld); end
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL rst_res_vld: got %b expected 0", res_vld); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    arg_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_pipe();
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, 1'b0, '0);
      checks++;
      if (s_arg_rdy !== 1'b1 || s_res_vld !== 1'b0 || s_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_%0d: got rdy=%b vld=%b err=%b expected rdy=1 vld=0 err=0", c, s_arg_rdy, s_res_vld, s_err);
      end
    end
  endtask

  task automatic test_fill();
    int n = 0;
    lat = 5;
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b1, 1'b0, 32'h11 * (n + 1));
      if (last_acc) n++;
    end
    run_cycle(1'b1, 1'b0, 32'h11 * (n + 1));
    if (last_acc) n++;
    checks++; if (n != 4) begin errors++; $display("FAIL fill_accepts: got %0d expected 4", n); end
    checks++; if (s_arg_rdy !== 1'b0) begin errors++; $display("FAIL fill_arg_rdy: got %b expected 0", s_arg_rdy); end
    checks++; if (s_res_vld !== 1'b1) begin errors++; $display("FAIL fill_res_vld: got %b expected 1", s_res_vld); end
    checks++; if (s_res !== 32'h11) begin errors++; $display("FAIL fill_head: got %h expected 00000011", s_res); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b expected 0", s_err); end
  endtask

  task automatic test_pop_refill();
    logic [31:0] exp_q [4];
    int np = 0;
    exp_q[0] = 32'h22; exp_q[1] = 32'h33; exp_q[2] = 32'h44; exp_q[3] = 32'h55;
    run_cycle(1'b1, 1'b1, 32'h55);
    checks++; if (last_pop !== 1'b1 || last_pop_data !== 32'h11) begin errors++; $display("FAIL pop_head: got pop=%b data=%h expected pop=1 data=00000011", last_pop, last_pop_data); end
    checks++; if (last_acc !== 1'b0) begin errors++; $display("FAIL pop_no_same_cycle_accept: got %b expected 0", last_acc); end
    run_cycle(1'b1, 1'b0, 32'h55);
    checks++; if (s_arg_rdy !== 1'b1 || last_acc !== 1'b1) begin errors++; $display("FAIL refill_accept: got rdy=%b acc=%b expected 1 1", s_arg_rdy, last_acc); end
    checks++; if (s_res !== 32'h22) begin errors++; $display("FAIL refill_head: got %h expected 00000022", s_res); end
    repeat (7) run_cycle(1'b0, 1'b0, '0);
    run_cycle(1'b0, 1'b0, '0);
    checks++; if (s_arg_rdy !== 1'b0 || s_err !== 1'b0) begin errors++; $display("FAIL refill_full: got rdy=%b err=%b expected rdy=0 err=0", s_arg_rdy, s_err); end
    for (int c = 0; c < 10; c++) begin
      run_cycle(1'b0, 1'b1, '0);
      if (last_pop) begin
        checks++;
        if (np >= 4 || last_pop_data !== exp_q[np < 4 ? np : 0]) begin
          errors++;
          $display("FAIL drain_%0d: got %h expected %h", np, last_pop_data, exp_q[np < 4 ? np : 0]);
        end
        np++;
      end
    end
    checks++; if (np != 4) begin errors++; $display("FAIL drain_count: got %0d expected 4", np); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic av, rr;
    lat = 33;
    while (got < 1000 && cyc < 40000) begin
      av = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      rr = ($urandom_range(0, 3) != 0);
      run_cycle(av, rr, sent);
      if (last_acc) sent++;
      if (last_pop) begin
        checks++;
        if (last_pop_data !== 32'(got)) begin errors++; $display("FAIL stream_order: got %0d expected %0d", last_pop_data, got); end
        got++;
      end
      cyc++;
    end
    checks++; if (got != 1000) begin errors++; $display("FAIL stream_timeout: got %0d results expected 1000", got); end
    run_cycle(1'b0, 1'b0, '0);
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL stream_err: got %b expected 0", s_err); end
    checks++; if (s_res_vld !== 1'b0 || s_arg_rdy !== 1'b1) begin errors++; $display("FAIL stream_idle: got vld=%b rdy=%b expected vld=0 rdy=1", s_res_vld, s_arg_rdy); end
    checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL stream_cnt: got %0d expected 0", dut.cnt_q); end
  endtask

  task automatic test_error_reset();
    lat = 5;
    inj_vld = 1'b1; inj_data = 32'hBAD;
    run_cycle(1'b0, 1'b0, '0);
    inj_vld = 1'b0;
    run_cycle(1'b1, 1'b0, 32'hA1);
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b expected 1", s_err); end
    checks++; if (s_res_vld !== 1'b1 || s_res !== 32'hBAD) begin errors++; $display("FAIL orphan_stored: got vld=%b res=%h expected vld=1 res=00000bad", s_res_vld, s_res); end
    run_cycle(1'b1, 1'b0, 32'hA2);
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", s_err); end
    rst = 1'b0;
    #1;
    checks++; if (res_vld !== 1'b0 || err !== 1'b0 || arg_rdy !== 1'b1) begin errors++; $display("FAIL midreset: got vld=%b err=%b rdy=%b expected vld=0 err=0 rdy=1", res_vld, err, arg_rdy); end
    repeat (2) run_cycle(1'b0, 1'b0, '0);
    rst = 1'b1;
    repeat (4) run_cycle(1'b0, 1'b0, '0);
    run_cycle(1'b0, 1'b0, '0);
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL stale_result_err: got %b expected 1", s_err); end
    checks++; if (s_res_vld !== 1'b1 || s_res !== 32'hA1) begin errors++; $display("FAIL stale_result_head: got vld=%b res=%h expected vld=1 res=000000a1", s_res_vld, s_res); end
  endtask

  task automatic test_overflow();
    int np = 0;
    do_reset();
    lat = 1;
    for (int k = 1; k <= 4; k++) run_cycle(1'b1, 1'b0, 32'(k));
    repeat (2) run_cycle(1'b0, 1'b0, '0);
    inj_vld = 1'b1; inj_data = 32'h99;
    run_cycle(1'b0, 1'b0, '0);
    inj_vld = 1'b0;
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL full_pre_err: got %b expected 0", s_err); end
    run_cycle(1'b0, 1'b0, '0);
    checks++; if (s_err !== 1'b1 || s_res !== 32'h1) begin errors++; $display("FAIL overflow: got err=%b head=%h expected err=1 head=00000001", s_err, s_res); end
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0, 1'b1, '0);
      if (last_pop) begin
        np++;
        checks++;
        if (last_pop_data !== 32'(np)) begin errors++; $display("FAIL overflow_order: got %h expected %h", last_pop_data, 32'(np)); end
      end
    end
    checks++; if (np != 4) begin errors++; $display("FAIL overflow_dropped: got %0d pops expected 4", np); end
  endtask

  task automatic test_bypass();
    do_reset();
    lat = 1;
    run_cycle(1'b1, 1'b1, 32'hDEADBEEF);
    run_cycle(1'b0, 1'b1, '0);
`ifdef FORMULA_PIPE_CREDIT_BUFFER_BYPASS_EN
    checks++; if (s_res_vld !== 1'b1 || s_res !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle: got vld=%b res=%h expected vld=1 res=deadbeef", s_res_vld, s_res); end
    run_cycle(1'b0, 1'b1, '0);
    checks++; if (s_res_vld !== 1'b0) begin errors++; $display("FAIL bypass_not_stored: got %b expected 0", s_res_vld); end
`else
    checks++; if (s_res_vld !== 1'b0) begin errors++; $display("FAIL nobypass_same_cycle: got %b expected 0", s_res_vld); end
    run_cycle(1'b0, 1'b1, '0);
    checks++; if (s_res_vld !== 1'b1 || s_res !== 32'hDEADBEEF) begin errors++; $display("FAIL nobypass_next_cycle: got vld=%b res=%h expected vld=1 res=deadbeef", s_res_vld, s_res); end
`endif
    run_cycle(1'b0, 1'b0, '0);
    checks++; if (s_err !== 1'b0 || s_res_vld !== 1'b0) begin errors++; $display("FAIL bypass_after: got err=%b vld=%b expected err=0 vld=0", s_err, s_res_vld); end
  endtask

  initial begin
    clear_pipe();
    test_reset();
    test_fill();
    test_pop_refill();
    test_stream();
    test_error_reset();
    test_overflow();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
